// File: rtl/sipo_rx_pkg.sv
// Shared types and sizing helpers for the serial word receiver.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a. SIPO_RX_PARITY_EN adds one even-parity bit to each frame.
package sipo_rx_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_t;

`ifdef SIPO_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Serial bits per frame: data bits plus an optional parity bit.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // The bit counter must be able to hold the value FRAME.
  function automatic int cnt_width(input int width);
    return $clog2(frame_len(width) + 1);
  endfunction

endpackage

// File: rtl/sipo_rx_fifo.sv
// Small synchronous FIFO holding completed receive words.
// Latency: a pushed word is visible at rdata/!empty one cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module sipo_rx_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage, pointers and occupancy; clear empties without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNTW'(1);
      else if (!do_push && do_pop) count <= count - CNTW'(1);
    end
  end

endmodule

// File: rtl/sipo_word_receiver.sv
// Reassembles LSB-first serial bits (sampled on shift_en) into words queued in a FIFO.
// Latency: word_valid rises the cycle after the edge sampling the last frame bit.
// Backpressure: valid/ready out; a word completing into a full FIFO with no pop is dropped and sets sticky overflow. Macro SIPO_RX_PARITY_EN adds even parity.
module sipo_word_receiver #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic             parity_err
);

  import sipo_rx_pkg::*;

  localparam int FRAME = frame_len(WIDTH);
  localparam int CW    = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] frame_word;
  logic [CW-1:0]    bit_cnt;
  rx_state_t        state;
  rx_state_t        state_next;
  logic             last_bit;
  logic             frame_ok;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign sr_next  = {serial_in, sr[WIDTH-1:1]};
  assign last_bit = shift_en && (bit_cnt == LAST_CNT);
  assign pop      = word_valid && word_ready && !clear;
  assign push_req = last_bit && frame_ok && !clear;

`ifdef SIPO_RX_PARITY_EN
  // The last serial bit is parity, so the data word is already complete in sr.
  assign frame_word = sr;
  assign frame_ok   = ~(^sr ^ serial_in);

  // One-cycle pulse for a frame rejected on parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= last_bit && !frame_ok && !clear;
  end
`else
  assign frame_word = sr_next;
  assign frame_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Shift register: LSB arrives first, so new bits enter at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sr <= '0;
    else if (clear)    sr <= '0;
    else if (shift_en) sr <= sr_next;
  end

  // Bit counter wraps to 0 on the last bit so frames can run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           bit_cnt <= '0;
    else if (clear)    bit_cnt <= '0;
    else if (shift_en) bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
  end

  // Receive state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_next;
  end

  // Next state: RECV while a partial word is held, IDLE between frames.
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE: if (shift_en && !last_bit) state_next = RX_RECV;
      RX_RECV: if (last_bit)              state_next = RX_IDLE;
      default:                            state_next = RX_IDLE;
    endcase
    if (clear) state_next = RX_IDLE;
  end

  // Sticky overflow: a completed word found the FIFO full with no pop to make room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   overflow <= 1'b0;
    else if (clear)                            overflow <= 1'b0;
    else if (push_req && fifo_full && !pop)    overflow <= 1'b1;
  end

  sipo_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push_req),
    .wdata (frame_word),
    .pop   (pop),
    .rdata (word_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign word_valid = !fifo_empty;

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Scoreboard bench for sipo_word_receiver: expected words queued as frames are sent.
// Latency: words are compared on the negedge where the DUT presents them with ready high.
// Backpressure: the model drops a word when the queue already holds FIFO_DEPTH entries.
module tb_sipo_word_receiver;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         serial_in = 1'b0;
  logic         shift_en = 1'b0;
  logic         clear = 1'b0;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         overflow;
  logic         parity_err;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf = 1'b0;

  sipo_word_receiver #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .shift_en   (shift_en),
    .clear      (clear),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every word accepted by the consumer must match the queue head.
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready && !clear) begin
      if (exp_q.size() == 0) check("spurious_word", 32'd1, 32'd0);
      else                   check("word_out", 32'(word_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    shift_en  = 1'b1;
    tick();
    shift_en  = 1'b0;
  endtask

  // Sends one frame; rdy_last raises word_ready just before the final bit edge.
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit bad_par, input bit rdy_last);
`ifdef SIPO_RX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    for (int i = 0; i < NB; i++) begin
      if (rdy_last && i == NB - 1) word_ready = 1'b1;
      if (i < W) send_bit(w[i]);
      else       send_bit((^w) ^ bad_par);
      if (i < NB - 1) repeat (gap) tick();
    end
    if (!bad_par) begin
      if (exp_q.size() < D) exp_q.push_back(w);
      else                  exp_ovf = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && word_valid; i++) tick();
    check({tag, "_valid_low"}, 32'(word_valid), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_word", 32'(word_out), 32'd0);

    // Reset mid-frame, then a clean frame must come through intact
    word_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(word_valid), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_perr", 32'(parity_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    send_word(4'h6, 0, 1'b0, 1'b0);
    drain("after_rst");

    // Single word latency and pop on the next edge
    send_word(4'hB, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("single_valid", 32'(word_valid), 32'd1);
    check("single_word", 32'(word_out), 32'hB);
    check("single_perr", 32'(parity_err), 32'd0);
    tick();
    check("single_popped", 32'(word_valid), 32'd0);

    // Gapped strobe
    send_word(4'h4, 3, 1'b0, 1'b0);
    drain("gapped");

    // Overflow with consumer stalled
    word_ready = 1'b0;
    send_word(4'h4, 0, 1'b0, 1'b0);
    send_word(4'hB, 0, 1'b0, 1'b0);
    send_word(4'h6, 0, 1'b0, 1'b0);
    tick();
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    check("ovf_valid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    drain("ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop on the completing edge
    do_clear();
    check("clr_ovf", 32'(overflow), 32'd0);
    word_ready = 1'b0;
    send_word(4'h1, 0, 1'b0, 1'b0);
    send_word(4'h2, 0, 1'b0, 1'b0);
    send_word(4'h9, 0, 1'b0, 1'b1);
    tick();
    check("fullpop_ovf", 32'(overflow), 32'd0);
    drain("fullpop");

    // Clear with a partial frame and a queued word
    word_ready = 1'b0;
    send_word(4'h3, 0, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    word_ready = 1'b1;
    do_clear();
    check("clear_valid", 32'(word_valid), 32'd0);
    check("clear_ovf", 32'(overflow), 32'd0);
    send_word(4'h5, 0, 1'b0, 1'b0);
    drain("after_clear");

`ifdef SIPO_RX_PARITY_EN
    // Bad parity: no push, one-cycle error pulse
    send_word(4'h5, 0, 1'b1, 1'b0);
    check("perr_pulse", 32'(parity_err), 32'd1);
    check("perr_valid", 32'(word_valid), 32'd0);
    tick();
    check("perr_low", 32'(parity_err), 32'd0);
    check("perr_ovf", 32'(overflow), 32'd0);
    drain("perr");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
